// File: rtl/flight_arming_sequencer_pkg.sv
// flight_arming_sequencer_pkg: shared widths, state encoding and fault codes
package flight_arming_sequencer_pkg;

    localparam int REC_VAL_BIT_WIDTH    = 8;
    localparam int MOTOR_RATE_BIT_WIDTH = 8;
    localparam int CNT_W                = 16;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        ARM_WAIT    = 3'd1,
        ARMED       = 3'd2,
        DISARM_WAIT = 3'd3,
        FAULT       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE        = 2'd0,
        FAULT_IMU_TIMEOUT = 2'd1,
        FAULT_IMU_LOST    = 2'd2,
        FAULT_KILL        = 2'd3
    } fault_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en,
                                                 input logic [CNT_W-1:0] lim);
        return (en && v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/flight_arming_sequencer_ms_tick_gen.sv
// flight_arming_sequencer_ms_tick_gen: prescaler emitting a 1-cycle tick every CLK_KHZ cycles
module flight_arming_sequencer_ms_tick_gen #(
    parameter int CLK_KHZ = 38000
) (
    input  logic sys_clk,
    input  logic reset,
    output logic tick
);

    localparam int W = CLK_KHZ > 1 ? $clog2(CLK_KHZ) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == W'(CLK_KHZ - 1);

    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge sys_clk) cnt_q <= reset ? '0 : cnt_d;

endmodule

// File: rtl/flight_arming_sequencer.sv
// flight_arming_sequencer: arm/disarm FSM with IMU watchdog, kill switch and motor rate gating
module flight_arming_sequencer
    import flight_arming_sequencer_pkg::*;
#(
    parameter int CLK_KHZ        = 38000,
    parameter int ARM_HOLD_MS    = 1000,
    parameter int DISARM_HOLD_MS = 1000,
    parameter int IMU_TIMEOUT_MS = 50,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] THR_LOW     = 8'd10,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_ARM     = 8'd240,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_DISARM  = 8'd15,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] KILL_THRESH = 8'd200
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic [REC_VAL_BIT_WIDTH-1:0]    throttle_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0]    yaw_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0]    swa_swb_val,
    input  logic                            imu_good,
    input  logic                            imu_valid_strobe,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate_in,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate_in,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate_in,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate_in,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate_out,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate_out,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate_out,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate_out,
    output logic                            armed,
    output logic [2:0]                      state,
    output logic [1:0]                      fault_code
);

    localparam logic [CNT_W-1:0] ARM_HOLD = CNT_W'(ARM_HOLD_MS);
    localparam logic [CNT_W-1:0] DIS_HOLD = CNT_W'(DISARM_HOLD_MS);
    localparam logic [CNT_W-1:0] HOLD_MAX = ARM_HOLD > DIS_HOLD ? ARM_HOLD : DIS_HOLD;
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(IMU_TIMEOUT_MS);

    logic tick;
    state_t state_q, state_d;
    fault_t fault_q, fault_d;
    logic [CNT_W-1:0] hold_q, hold_d, wdog_q, wdog_d;
    logic armed_q, armed_d, arm_done;
    logic thr_lo, arm_g, dis_g, kill, timeout;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_in [4];
    logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_q [4];
    logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_d [4];

    flight_arming_sequencer_ms_tick_gen #(.CLK_KHZ(CLK_KHZ)) u_tick (
        .sys_clk(sys_clk),
        .reset  (reset),
        .tick   (tick)
    );

    assign rate_in = '{motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in};
    assign thr_lo  = throttle_val <= THR_LOW;
    assign arm_g   = thr_lo && yaw_val >= YAW_ARM;
    assign dis_g   = thr_lo && yaw_val <= YAW_DISARM;
    assign kill    = swa_swb_val >= KILL_THRESH;
    assign timeout = wdog_q == WDOG_MAX;

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        arm_done = 1'b0;
        if (kill) begin
            state_d = DISARMED;
            fault_d = FAULT_KILL;
        end else begin
            case (state_q)
                DISARMED: state_d = (arm_g && imu_good) ? ARM_WAIT : DISARMED;
                ARM_WAIT: begin
                    arm_done = arm_g && imu_good && hold_q == ARM_HOLD;
                    state_d  = !(arm_g && imu_good) ? DISARMED : arm_done ? ARMED : ARM_WAIT;
                end
                ARMED, DISARM_WAIT: begin
                    fault_d = timeout ? FAULT_IMU_TIMEOUT : !imu_good ? FAULT_IMU_LOST : fault_q;
                    if (timeout || !imu_good)
                        state_d = FAULT;
                    else if (state_q == ARMED)
                        state_d = dis_g ? DISARM_WAIT : ARMED;
                    else
                        state_d = !dis_g ? ARMED : (hold_q == DIS_HOLD) ? DISARMED : DISARM_WAIT;
                end
                FAULT: state_d = (imu_good && thr_lo && !arm_g && !timeout) ? DISARMED : FAULT;
                default: state_d = DISARMED;
            endcase
        end
        if (!kill && state_d == DISARMED)
            fault_d = FAULT_NONE;
        hold_d  = state_d != state_q ? '0 : sat_inc(hold_q, tick, HOLD_MAX);
        wdog_d  = (imu_valid_strobe || arm_done) ? '0 : sat_inc(wdog_q, tick, WDOG_MAX);
        armed_d = state_d == ARMED || state_d == DISARM_WAIT;
        // Gate on the next state so rates drop on the same edge the craft leaves the armed set
        for (int i = 0; i < 4; i++)
            rate_d[i] = armed_d ? rate_in[i] : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= DISARMED;
            fault_q <= FAULT_NONE;
            hold_q  <= '0;
            wdog_q  <= '0;
            armed_q <= 1'b0;
            rate_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            hold_q  <= hold_d;
            wdog_q  <= wdog_d;
            armed_q <= armed_d;
            rate_q  <= rate_d;
        end
    end

    assign state            = state_q;
    assign fault_code       = fault_q;
    assign armed            = armed_q;
    assign motor_1_rate_out = rate_q[0];
    assign motor_2_rate_out = rate_q[1];
    assign motor_3_rate_out = rate_q[2];
    assign motor_4_rate_out = rate_q[3];

endmodule

// File: tb/tb_flight_arming_sequencer.sv
// tb_flight_arming_sequencer: vector table plus scoreboarded sequences for the arming sequencer
module tb_flight_arming_sequencer;

    localparam int CK   = 4;
    localparam int HOLD = 3;
    localparam int TO   = 2;

    logic sys_clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] thr = 8'd0, yaw = 8'd128, swa = 8'd0;
    logic imu_good = 1'b0, strobe = 1'b0;
    logic [3:0][7:0] rin;
    logic [3:0][7:0] rout;
    logic [7:0] ro1, ro2, ro3, ro4;
    logic armed;
    logic [2:0] state;
    logic [1:0] fault_code;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit strobe_en = 1'b0;

    int m_st = 0, m_fc = 0, m_hold = 0, m_wd = 0, m_pre = 0;

    typedef struct packed {
        logic [2:0]      st;
        logic            arm;
        logic [1:0]      fc;
        logic [3:0][7:0] r;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] thr, yaw, swa;
        logic       good;
        int         st, fc;
    } vec_t;
    vec_t vecs[7];

    always #5 sys_clk = ~sys_clk;

    assign rout = {ro4, ro3, ro2, ro1};

    flight_arming_sequencer #(
        .CLK_KHZ(CK), .ARM_HOLD_MS(HOLD), .DISARM_HOLD_MS(HOLD), .IMU_TIMEOUT_MS(TO)
    ) dut (
        .sys_clk(sys_clk), .reset(reset),
        .throttle_val(thr), .yaw_val(yaw), .swa_swb_val(swa),
        .imu_good(imu_good), .imu_valid_strobe(strobe),
        .motor_1_rate_in(rin[0]), .motor_2_rate_in(rin[1]),
        .motor_3_rate_in(rin[2]), .motor_4_rate_in(rin[3]),
        .motor_1_rate_out(ro1), .motor_2_rate_out(ro2),
        .motor_3_rate_out(ro3), .motor_4_rate_out(ro4),
        .armed(armed), .state(state), .fault_code(fault_code)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural reference of one clock edge, written from the arming rules
    task automatic model(output exp_t e);
        bit tick, thr_lo, arm_g, dis_g, kill, tmo, wclr;
        int ns, nfc;
        tick = (m_pre == CK - 1);
        if (reset) begin
            m_st = 0; m_fc = 0; m_hold = 0; m_wd = 0; m_pre = 0;
            e = '0;
        end else begin
            thr_lo = thr <= 8'd10;
            arm_g  = thr_lo && yaw >= 8'd240;
            dis_g  = thr_lo && yaw <= 8'd15;
            kill   = swa >= 8'd200;
            tmo    = m_wd == TO;
            ns = m_st; nfc = m_fc; wclr = strobe;
            if (kill) begin ns = 0; nfc = 3; end
            else if (m_st == 0) begin if (arm_g && imu_good) ns = 1; end
            else if (m_st == 1) begin
                if (!arm_g || !imu_good) ns = 0;
                else if (m_hold == HOLD) begin ns = 2; wclr = 1; end
            end
            else if (m_st == 4) begin if (imu_good && thr_lo && !arm_g && !tmo) ns = 0; end
            else if (tmo) begin ns = 4; nfc = 1; end
            else if (!imu_good) begin ns = 4; nfc = 2; end
            else if (m_st == 2) begin if (dis_g) ns = 3; end
            else if (!dis_g) ns = 2;
            else if (m_hold == HOLD) ns = 0;
            if (!kill && ns == 0) nfc = 0;
            m_hold = (ns != m_st) ? 0 : (tick && m_hold < HOLD) ? m_hold + 1 : m_hold;
            m_wd   = wclr ? 0 : (tick && m_wd < TO) ? m_wd + 1 : m_wd;
            m_pre  = tick ? 0 : m_pre + 1;
            m_st = ns; m_fc = nfc;
            e.st  = 3'(ns);
            e.fc  = 2'(nfc);
            e.arm = (ns == 2 || ns == 3);
            e.r   = e.arm ? rin : '0;
        end
    endtask

    task automatic step();
        exp_t e;
        strobe = strobe_en && (cyc % 4 == 0);
        model(e);
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("sb_state", int'(state), int'(e.st));
        chk("sb_armed", int'(armed), int'(e.arm));
        chk("sb_fault", int'(fault_code), int'(e.fc));
        chk("sb_rates", int'(rout), int'(e.r));
    endtask

    task automatic run_until(input string nm, input int st, input int budget);
        for (int i = 0; i < budget && int'(state) != st; i++) step();
        chk(nm, int'(state), st);
    endtask

    task automatic do_arm(input string nm);
        thr = 8'd5; yaw = 8'd250; swa = 8'd0; imu_good = 1'b1; strobe_en = 1'b1;
        run_until(nm, 2, 30);
        yaw = 8'd128;
    endtask

    initial begin
        vecs[0] = '{8'd10,  8'd240, 8'd0,   1'b1, 1, 0};
        vecs[1] = '{8'd11,  8'd240, 8'd0,   1'b1, 0, 0};
        vecs[2] = '{8'd10,  8'd239, 8'd0,   1'b1, 0, 0};
        vecs[3] = '{8'd0,   8'd255, 8'd199, 1'b1, 1, 0};
        vecs[4] = '{8'd0,   8'd255, 8'd200, 1'b1, 0, 3};
        vecs[5] = '{8'd5,   8'd250, 8'd0,   1'b0, 0, 0};
        vecs[6] = '{8'd255, 8'd255, 8'd0,   1'b1, 0, 0};

        rin = {8'd200, 8'd200, 8'd200, 8'd200};
        step();
        step();
        chk("reset_state", int'(state), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_fault", int'(fault_code), 0);
        chk("reset_rates", int'(rout), 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            thr = vecs[k].thr; yaw = vecs[k].yaw; swa = vecs[k].swa; imu_good = vecs[k].good;
            step();
            chk($sformatf("vec%0d_state", k), int'(state), vecs[k].st);
            chk($sformatf("vec%0d_fault", k), int'(fault_code), vecs[k].fc);
            thr = 8'd5; yaw = 8'd128; swa = 8'd0; imu_good = 1'b1;
            step();
        end

        thr = 8'd5; yaw = 8'd250; strobe_en = 1'b1;
        run_until("abort_enter_wait", 1, 4);
        repeat (8) step();
        chk("abort_still_wait", int'(state), 1);
        yaw = 8'd128;
        step();
        chk("abort_disarmed", int'(state), 0);
        chk("abort_rates", int'(rout), 0);

        do_arm("arm_reached");
        rin = {8'd123, 8'd122, 8'd121, 8'd120};
        step();
        chk("arm_rate_pass", int'(ro1), 120);
        chk("arm_rate4_pass", int'(ro4), 123);

        strobe_en = 1'b0;
        run_until("wdog_fault", 4, 20);
        chk("wdog_code", int'(fault_code), 1);
        chk("wdog_rates", int'(rout), 0);
        chk("wdog_armed", int'(armed), 0);
        repeat (5) step();
        chk("wdog_held", int'(state), 4);
        strobe_en = 1'b1; thr = 8'd5; yaw = 8'd128;
        run_until("wdog_recover", 0, 10);
        chk("wdog_code_clear", int'(fault_code), 0);

        do_arm("kill_arm");
        swa = 8'd255;
        step();
        chk("kill_state", int'(state), 0);
        chk("kill_code", int'(fault_code), 3);
        chk("kill_rates", int'(rout), 0);
        yaw = 8'd250;
        repeat (10) step();
        chk("kill_ignore_arm", int'(state), 0);
        chk("kill_code_held", int'(fault_code), 3);
        swa = 8'd0; yaw = 8'd128;
        step();
        chk("kill_release", int'(fault_code), 0);

        do_arm("disarm_arm");
        yaw = 8'd10;
        step();
        chk("disarm_wait", int'(state), 3);
        repeat (4) begin
            step();
            chk("disarm_no_gate", int'(rout), int'(rin));
        end
        yaw = 8'd128;
        step();
        chk("disarm_abort", int'(state), 2);
        chk("disarm_abort_rate", int'(ro1), 120);
        yaw = 8'd10;
        run_until("disarm_done", 0, 30);
        chk("disarm_rates", int'(rout), 0);

        yaw = 8'd128;
        do_arm("imu_arm");
        imu_good = 1'b0;
        step();
        chk("imu_lost_state", int'(state), 4);
        chk("imu_lost_code", int'(fault_code), 2);
        imu_good = 1'b1;
        run_until("imu_recover", 0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
